control_sequencer: RTL and testbench

- Hardwired multi-cycle control unit that sits directly upstream of the CPU datapath.
- Drives every datapath strobe (register select/in/out, PC, IR, MAR/MDR, RAM read/write, Y/Z, HI/LO, I/O ports, CON) from the instruction register and the branch condition flag.
- Moore FSM: fetch phase, then one opcode-specific execute sequence, then back to fetch.

---
 rtl/control_sequencer.sv | 151 +++++++++++++++
 tb/tb_control_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired multi-cycle Moore control unit driving every datapath strobe
module control_sequencer #(
   parameter int MEM_WAIT    = 1,
   parameter int DIVMUL_HOLD = 1
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        stop,
   input  logic [31:0] ir,
   input  logic        con,
   output logic [2:0]  gr_sel,
   output logic [2:0]  reg_ctl,
   output logic [2:0]  pc_ctl,
   output logic [5:0]  mem_ctl,
   output logic [5:0]  alu_ctl,
   output logic [3:0]  hilo_ctl,
   output logic [1:0]  io_ctl,
   output logic [4:0]  alu_op,
   output logic        run
);
   typedef enum logic [3:0] {RST, F0, F1, F2, F3, E3, E4, E5, E6, E7, HALT} state_t;
   state_t state, nxt, last_e;
   logic [4:0] cnt, op;
   logic is_r, is_imm, is_ldi, is_ld, is_st, is_mem, is_md, is_nn, is_br, is_jr, is_jal;
   logic is_in, is_out, is_mfhi, is_mflo, is_halt, mem_done, md_done, hold;
   logic gra, grb, grc, rin, rout, baout, pcout, pcin, incpc;
   logic marin, mdrin, mdrout, rd, ramwrite, irin;
   logic yin, zin, zhi, zlo, cout, conin, hiin, loin, hiout, loout, outp_in, inp_out;
   logic unused_ir;
   assign op        = ir[31:27];
   assign unused_ir = ^ir[26:0];
   assign is_r      = (op >= 5'd3) && (op <= 5'd11);
   assign is_ldi    = op == 5'd1;
   assign is_imm    = is_ldi || ((op >= 5'd12) && (op <= 5'd14));
   assign is_ld     = op == 5'd0;
   assign is_st     = op == 5'd2;
   assign is_mem    = is_ld || is_st;
   assign is_md     = (op == 5'd15) || (op == 5'd16);
   assign is_nn     = (op == 5'd17) || (op == 5'd18);
   assign is_br     = op == 5'd19;
   assign is_jr     = op == 5'd20;
   assign is_jal    = op == 5'd21;
   assign is_in     = op == 5'd22;
   assign is_out    = op == 5'd23;
   assign is_mfhi   = op == 5'd24;
   assign is_mflo   = op == 5'd25;
   assign is_halt   = op == 5'd27;
   assign mem_done  = cnt == 5'(MEM_WAIT - 1);
   assign md_done   = cnt == 5'(DIVMUL_HOLD - 1);
   // Memory waits and the mul/div Zin hold stretch their state in place.
   assign hold = (state == F2 && !mem_done) || (state == E6 && is_ld && !mem_done) ||
                 (state == E4 && is_md && !md_done);
   assign last_e = is_mem ? E7 : (is_md || is_br) ? E6 : (is_r || is_imm) ? E5 :
                   (is_nn || is_jal) ? E4 : E3;
   always_comb begin
      nxt = state_t'(state + 4'd1);
      if (hold || state == HALT) nxt = state;
      else if (state == E3 && is_halt) nxt = HALT;
      else if (state == last_e) nxt = stop ? HALT : F0;
   end
   always_ff @(posedge clock or negedge clear)
      if (!clear) begin
         state <= RST;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= hold ? cnt + 5'd1 : 5'd0;
      end
   always_comb begin
      {gra, grb, grc, rin, rout, baout, pcout, pcin, incpc} = '0;
      {marin, mdrin, mdrout, rd, ramwrite, irin} = '0;
      {yin, zin, zhi, zlo, cout, conin, hiin, loin, hiout, loout, outp_in, inp_out} = '0;
      alu_op = '0;
      case (state)
         F0: begin
            {pcout, marin, incpc, zin} = 4'hf;
            alu_op = 5'd3;
         end
         F1: {zlo, pcin, rd} = 3'b111;
         F2: {rd, mdrin} = {1'b1, mem_done};
         F3: {mdrout, irin} = 2'b11;
         E3: begin
            grb     = is_r || is_imm || is_mem || is_nn || is_jal;
            gra     = is_md || is_br || is_jr || is_in || is_out || is_mfhi || is_mflo;
            yin     = is_r || is_imm || is_mem || is_md;
            rout    = is_r || (is_imm && !is_ldi) || is_md || is_nn || is_br || is_jr || is_out;
            baout   = is_mem || is_ldi;
            zin     = is_nn;
            alu_op  = is_nn ? op : 5'd0;
            conin   = is_br;
            pcin    = is_jr;
            pcout   = is_jal;
            rin     = is_jal || is_in || is_mfhi || is_mflo;
            inp_out = is_in;
            outp_in = is_out;
            hiout   = is_mfhi;
            loout   = is_mflo;
         end
         E4: begin
            grc    = is_r;
            grb    = is_md;
            gra    = is_nn || is_jal;
            rout   = is_r || is_md || is_jal;
            zin    = is_r || is_imm || is_mem || is_md;
            cout   = is_imm || is_mem;
            alu_op = (is_r || is_md) ? op : (op == 5'd13) ? 5'd5 : (op == 5'd14) ? 5'd6 :
                     (is_imm || is_mem) ? 5'd3 : 5'd0;
            zlo    = is_nn;
            rin    = is_nn;
            pcout  = is_br;
            yin    = is_br;
            pcin   = is_jal;
         end
         E5: begin
            zlo    = is_r || is_imm || is_mem || is_md;
            gra    = is_r || is_imm;
            rin    = is_r || is_imm;
            marin  = is_mem;
            loin   = is_md;
            cout   = is_br;
            zin    = is_br;
            alu_op = is_br ? 5'd3 : 5'd0;
         end
         E6: begin
            rd    = is_ld;
            mdrin = (is_ld && mem_done) || is_st;
            gra   = is_st;
            rout  = is_st;
            zhi   = is_md;
            hiin  = is_md;
            zlo   = is_br && con;
            pcin  = is_br && con;
         end
         E7: begin
            mdrout   = is_ld;
            gra      = is_ld;
            rin      = is_ld;
            ramwrite = is_st;
         end
         default: ;
      endcase
   end
   assign gr_sel   = {gra, grb, grc};
   assign reg_ctl  = {rin, rout, baout};
   assign pc_ctl   = {pcout, pcin, incpc};
   assign mem_ctl  = {marin, mdrin, mdrout, rd, ramwrite, irin};
   assign alu_ctl  = {yin, zin, zhi, zlo, cout, conin};
   assign hilo_ctl = {hiin, loin, hiout, loout};
   assign io_ctl   = {outp_in, inp_out};
   assign run      = state != RST && state != HALT;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized bench comparing every strobe cycle against a per-instruction sequence model
module tb_control_sequencer;
   localparam int MW = 2;
   localparam int DH = 3;
   localparam logic [32:0] RUN = 33'h1 << 0, INP = 33'h1 << 6, OUTP = 33'h1 << 7;
   localparam logic [32:0] LOOUT = 33'h1 << 8, HIOUT = 33'h1 << 9, LOIN = 33'h1 << 10, HIIN = 33'h1 << 11;
   localparam logic [32:0] CONIN = 33'h1 << 12, COUT = 33'h1 << 13, ZLO = 33'h1 << 14, ZHI = 33'h1 << 15;
   localparam logic [32:0] ZIN = 33'h1 << 16, YIN = 33'h1 << 17, IRIN = 33'h1 << 18, RAMWR = 33'h1 << 19;
   localparam logic [32:0] RD = 33'h1 << 20, MDROUT = 33'h1 << 21, MDRIN = 33'h1 << 22, MARIN = 33'h1 << 23;
   localparam logic [32:0] INCPC = 33'h1 << 24, PCIN = 33'h1 << 25, PCOUT = 33'h1 << 26, BAOUT = 33'h1 << 27;
   localparam logic [32:0] ROUT = 33'h1 << 28, RIN = 33'h1 << 29, GRC = 33'h1 << 30, GRB = 33'h1 << 31;
   localparam logic [32:0] GRA = 33'h1 << 32;
   localparam logic [32:0] DRV = ROUT | BAOUT | PCOUT | MDROUT | ZHI | ZLO | HIOUT | LOOUT | INP | COUT;
   logic clock = 0, clear, stop, con;
   logic [31:0] ir;
   logic [2:0] gr_sel, reg_ctl, pc_ctl;
   logic [5:0] mem_ctl, alu_ctl;
   logic [3:0] hilo_ctl;
   logic [1:0] io_ctl;
   logic [4:0] alu_op;
   logic run;
   logic [32:0] obs;
   logic [32:0] exp_q[$];
   int errors = 0, checks = 0;
   control_sequencer #(.MEM_WAIT(MW), .DIVMUL_HOLD(DH)) dut (
      .clock(clock), .clear(clear), .stop(stop), .ir(ir), .con(con),
      .gr_sel(gr_sel), .reg_ctl(reg_ctl), .pc_ctl(pc_ctl), .mem_ctl(mem_ctl),
      .alu_ctl(alu_ctl), .hilo_ctl(hilo_ctl), .io_ctl(io_ctl), .alu_op(alu_op), .run(run)
   );
   always #5 clock = ~clock;
   assign obs = {gr_sel, reg_ctl, pc_ctl, mem_ctl, alu_ctl, hilo_ctl, io_ctl, alu_op, run};
   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask
   function automatic logic [32:0] alu(input logic [4:0] x);
      return {27'd0, x, 1'b0};
   endfunction
   function automatic void push(input logic [32:0] v);
      exp_q.push_back(v | RUN);
   endfunction
   // Whole-instruction expected strobe sequence, one entry per clock, fetch included.
   task automatic build(input logic [4:0] op, input logic c);
      exp_q = {};
      push(PCOUT | MARIN | INCPC | ZIN | alu(5'd3));
      push(ZLO | PCIN | RD);
      for (int k = 1; k <= MW; k++) push(RD | ((k == MW) ? MDRIN : 33'd0));
      push(MDROUT | IRIN);
      if (op >= 5'd3 && op <= 5'd11) begin
         push(GRB | ROUT | YIN); push(GRC | ROUT | ZIN | alu(op)); push(ZLO | GRA | RIN);
      end else if (op == 5'd1 || (op >= 5'd12 && op <= 5'd14)) begin
         push(GRB | YIN | ((op == 5'd1) ? BAOUT : ROUT));
         push(COUT | ZIN | alu((op == 5'd13) ? 5'd5 : (op == 5'd14) ? 5'd6 : 5'd3));
         push(ZLO | GRA | RIN);
      end else if (op == 5'd0 || op == 5'd2) begin
         push(GRB | BAOUT | YIN); push(COUT | ZIN | alu(5'd3)); push(ZLO | MARIN);
         if (op == 5'd0) begin
            for (int k = 1; k <= MW; k++) push(RD | ((k == MW) ? MDRIN : 33'd0));
            push(MDROUT | GRA | RIN);
         end else begin
            push(GRA | ROUT | MDRIN); push(RAMWR);
         end
      end else if (op == 5'd15 || op == 5'd16) begin
         push(GRA | ROUT | YIN);
         for (int k = 0; k < DH; k++) push(GRB | ROUT | ZIN | alu(op));
         push(ZLO | LOIN); push(ZHI | HIIN);
      end else if (op == 5'd17 || op == 5'd18) begin
         push(GRB | ROUT | ZIN | alu(op)); push(ZLO | GRA | RIN);
      end else begin
         case (op)
            5'd19: begin
               push(GRA | ROUT | CONIN); push(PCOUT | YIN); push(COUT | ZIN | alu(5'd3));
               push(c ? (ZLO | PCIN) : 33'd0);
            end
            5'd20: push(GRA | ROUT | PCIN);
            5'd21: begin push(PCOUT | GRB | RIN); push(GRA | ROUT | PCIN); end
            5'd22: push(INP | GRA | RIN);
            5'd23: push(GRA | ROUT | OUTP);
            5'd24: push(HIOUT | GRA | RIN);
            5'd25: push(LOOUT | GRA | RIN);
            default: push(33'd0);
         endcase
      end
   endtask
   task automatic do_reset();
      clear = 0;
      stop  = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("reset_hold", obs, 33'd0);
      end
      clear = 1;
      @(negedge clock);
   endtask
   task automatic halt_hold();
      for (int i = 0; i < 20; i++) begin
         chk("halt_idle", obs, 33'd0);
         stop = 1'($urandom);
         con  = 1'($urandom);
         ir   = $urandom;
         @(negedge clock);
      end
      do_reset();
   endtask
   // Entered at the negedge of F0; leaves at the negedge after the last execute cycle.
   task automatic run_instr(input logic [31:0] instr, input logic c, input bit stop_end, input int abort_at);
      int fl;
      build(instr[31:27], c);
      fl  = 3 + MW;
      con = c;
      ir  = $urandom;
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("op%0d_cyc%0d", instr[31:27], i), obs, exp_q[i]);
         chk("bus_excl", 33'(($countones(obs & DRV) <= 1) && !(obs[20] && obs[19])), 33'd1);
         if (i == abort_at) begin
            #2 clear = 0;
            #1 chk("async_reset", obs, 33'd0);
            do_reset();
            return;
         end
         if (i == fl - 1) ir = instr;
         stop = (i == exp_q.size() - 1) ? stop_end : 1'($urandom);
         @(negedge clock);
      end
      stop = 0;
   endtask
   initial begin
      clear = 0; stop = 0; con = 0; ir = '0;
      do_reset();
      run_instr(32'h19890000, 1'b0, 1'b0, -1);
      run_instr({5'd0, 27'h0123456}, 1'b1, 1'b0, -1);
      run_instr(32'h98000000, 1'b0, 1'b0, -1);
      run_instr(32'h98000000, 1'b1, 1'b0, -1);
      run_instr(32'h80000000, 1'b0, 1'b0, -1);
      for (int o = 0; o < 32; o++)
         if (o != 27) run_instr({5'(o), 27'($urandom)}, 1'($urandom), 1'b0, -1);
      for (int n = 0; n < 80; n++) begin
         logic [31:0] w;
         w = $urandom;
         if (w[31:27] == 5'd27) w[31:27] = 5'd26;
         run_instr(w, 1'($urandom), 1'b0, -1);
      end
      run_instr(32'h19890000, 1'b0, 1'b0, 3 + MW + 1);
      run_instr(32'h19890000, 1'b0, 1'b0, -1);
      run_instr(32'h19890000, 1'b1, 1'b1, -1);
      halt_hold();
      run_instr(32'hD8000000, 1'b0, 1'b0, -1);
      halt_hold();
      run_instr(32'h19890000, 1'b0, 1'b0, -1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
